scoreboard_hazard_unit_p: RTL and testbench

- Parametrised next-generation scoreboard for the in-order RV32I issue stage, with custom long-latency units (AES and similar) on custom-0.
- Detects RAW hazards against in-flight fixed-latency writers, with a configurable forwarding point.
- Tracks up to LONG_UNITS multi-cycle units, each owning one destination register and releasing it on a done pulse.
- Generates a multi-cycle kill window after branch or exception redirect. Sits between decode and the execute-stage issue register.

---
 rtl/scoreboard_pkg.sv | 32 +++
 rtl/sb_decode.sv | 46 ++++
 rtl/scoreboard_hazard_unit_p.sv | 167 ++++++++++++++++
 tb/tb_scoreboard_hazard_unit_p.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// ----------------------------------------------------------------------------
// scoreboard_pkg : opcode constants and decode classes for the hazard unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package scoreboard_pkg;

  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_OP      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_OPIMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;

  typedef enum logic [2:0] {
    FU_NONE       = 3'd0,
    FU_RD_ONLY    = 3'd1,
    FU_RS1_RS2_RD = 3'd2,
    FU_RS1_RS2    = 3'd3,
    FU_RS1_RD     = 3'd4,
    FU_LONG       = 3'd5
  } fu_class_t;

endpackage

`default_nettype wire

// File: rtl/sb_decode.sv
// ----------------------------------------------------------------------------
// sb_decode : maps an opcode to its operand-usage class (combinational)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sb_decode
  import scoreboard_pkg::*;
(
  input  logic [6:0] op_code_i,
  output fu_class_t  fu_class_o,
  output logic       use_rs1_o,
  output logic       use_rs2_o,
  output logic       writes_rd_o
);

  always_comb begin
    fu_class_o = FU_NONE;
    unique case (op_code_i)
      OP_LUI, OP_AUIPC, OP_JAL:       fu_class_o = FU_RD_ONLY;
      OP_OP:                          fu_class_o = FU_RS1_RS2_RD;
      // JALR intentionally grouped with branches/stores: its rd is not tracked
      OP_BRANCH, OP_STORE, OP_JALR:   fu_class_o = FU_RS1_RS2;
      OP_OPIMM, OP_LOAD, OP_SYSTEM:   fu_class_o = FU_RS1_RD;
      OP_CUSTOM0:                     fu_class_o = FU_LONG;
      default:                        fu_class_o = FU_NONE;
    endcase
  end

  always_comb begin
    use_rs1_o   = 1'b0;
    use_rs2_o   = 1'b0;
    writes_rd_o = 1'b0;
    case (fu_class_o)
      FU_RD_ONLY:    writes_rd_o = 1'b1;
      FU_RS1_RS2_RD: begin use_rs1_o = 1'b1; use_rs2_o = 1'b1; writes_rd_o = 1'b1; end
      FU_RS1_RS2:    begin use_rs1_o = 1'b1; use_rs2_o = 1'b1; end
      FU_RS1_RD:     begin use_rs1_o = 1'b1; writes_rd_o = 1'b1; end
      FU_LONG:       begin use_rs1_o = 1'b1; use_rs2_o = 1'b1; writes_rd_o = 1'b1; end
      default:       ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/scoreboard_hazard_unit_p.sv
// ----------------------------------------------------------------------------
// scoreboard_hazard_unit_p : RAW/WAW/structural stall and redirect kill window
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module scoreboard_hazard_unit_p
  import scoreboard_pkg::*;
#(
  parameter  int NREG        = 32,
  parameter  int WB_LAT      = 3,
  parameter  int FWD_LAT     = 1,
  parameter  int KILL_CYCLES = 2,
  parameter  int LONG_UNITS  = 2,
  localparam int RW          = $clog2(NREG),
  localparam int UW          = (LONG_UNITS > 1) ? $clog2(LONG_UNITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [6:0]            op_code,
  input  logic [2:0]            funct3,
  input  logic [RW-1:0]         rs1,
  input  logic [RW-1:0]         rs2,
  input  logic [RW-1:0]         rd,
  input  logic                  btaken,
  input  logic                  exception,
  input  logic                  discard,
  input  logic [LONG_UNITS-1:0] lu_done,
  output logic                  stall,
  output logic                  kill,
  output logic [LONG_UNITS-1:0] lu_busy,
  output logic                  sb_busy
);

  localparam logic [2:0]    C_WB   = 3'(WB_LAT);
  localparam logic [2:0]    C_FWD  = 3'(FWD_LAT);
  localparam logic [2:0]    C_KILL = 3'(KILL_CYCLES - 1);
  localparam logic [RW-1:0] C_X0   = '0;

  logic [2:0]            cnt_q [NREG];
  logic [2:0]            cnt_d [NREG];
  logic [NREG-1:0]       own_valid_q, own_valid_d;
  logic [UW-1:0]         own_id_q [NREG];
  logic [UW-1:0]         own_id_d [NREG];
  logic [LONG_UNITS-1:0] lu_busy_q, lu_busy_d;
  logic [RW-1:0]         lu_rd_q [LONG_UNITS];
  logic [RW-1:0]         lu_rd_d [LONG_UNITS];
  logic [2:0]            kcnt_q, kcnt_d;
  logic                  rdy_q;

  fu_class_t     w_class;
  logic          w_use_rs1, w_use_rs2, w_writes_rd, w_is_long;
  logic [UW-1:0] w_u;
  logic          w_u_ok;
  logic          w_hz1, w_hz2, w_waw, w_struct;
  logic          w_stall_raw, w_kill, w_issue;
  logic          w_unused;

  sb_decode u_decode (
    .op_code_i   (op_code),
    .fu_class_o  (w_class),
    .use_rs1_o   (w_use_rs1),
    .use_rs2_o   (w_use_rs2),
    .writes_rd_o (w_writes_rd)
  );

  assign w_is_long = (w_class == FU_LONG);
  assign w_u       = funct3[UW-1:0];
  assign w_u_ok    = ({1'b0, w_u} < (UW+1)'(LONG_UNITS));
  assign w_unused  = ^funct3;

  always_comb begin
    w_hz1       = w_use_rs1 && (rs1 != C_X0) && ((cnt_q[rs1] > C_FWD) || own_valid_q[rs1]);
    w_hz2       = w_use_rs2 && (rs2 != C_X0) && ((cnt_q[rs2] > C_FWD) || own_valid_q[rs2]);
    w_waw       = w_writes_rd && own_valid_q[rd];
    w_struct    = w_is_long && w_u_ok && lu_busy_q[w_u] && !lu_done[w_u];
    w_stall_raw = issue_valid && (w_hz1 || w_hz2 || w_waw || w_struct);
    // rdy_q keeps the kill output quiet during the first cycle after reset
    w_kill      = (btaken || exception || (kcnt_q != 3'd0)) && !w_stall_raw && !discard && rdy_q;
    w_issue     = issue_valid && !w_stall_raw && !w_kill;
  end

  assign stall   = w_stall_raw && !w_kill;
  assign kill    = w_kill;
  assign lu_busy = lu_busy_q;

  always_comb begin
    sb_busy = |lu_busy_q;
    for (int r = 0; r < NREG; r++) begin
      sb_busy = sb_busy || (cnt_q[r] != 3'd0);
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r]    = (cnt_q[r] != 3'd0) ? cnt_q[r] - 3'd1 : 3'd0;
      own_id_d[r] = own_id_q[r];
    end
    own_valid_d = own_valid_q;
    lu_busy_d   = lu_busy_q;
    for (int u = 0; u < LONG_UNITS; u++) begin
      lu_rd_d[u] = lu_rd_q[u];
    end

    if (w_issue && w_writes_rd && !w_is_long && (rd != C_X0)) begin
      cnt_d[rd] = C_WB;
    end

    for (int u = 0; u < LONG_UNITS; u++) begin
      if (lu_done[u] && lu_busy_q[u]) begin
        lu_busy_d[u] = 1'b0;
        if (own_id_q[lu_rd_q[u]] == UW'(u)) begin
          own_valid_d[lu_rd_q[u]] = 1'b0;
        end
      end
    end

    // Applied after the releases so a same-edge re-issue keeps its own rd
    if (w_issue && w_is_long && w_u_ok) begin
      lu_busy_d[w_u] = 1'b1;
      lu_rd_d[w_u]   = rd;
      if (rd != C_X0) begin
        own_valid_d[rd] = 1'b1;
        own_id_d[rd]    = w_u;
      end
    end

    kcnt_d = kcnt_q;
    if (rdy_q) begin
      if (discard) begin
        kcnt_d = 3'd0;
      end else if (btaken || exception) begin
        kcnt_d = C_KILL;
      end else if ((kcnt_q != 3'd0) && w_kill) begin
        kcnt_d = kcnt_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r]    <= 3'd0;
        own_id_q[r] <= '0;
      end
      for (int u = 0; u < LONG_UNITS; u++) begin
        lu_rd_q[u] <= '0;
      end
      own_valid_q <= '0;
      lu_busy_q   <= '0;
      kcnt_q      <= 3'd0;
      rdy_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      own_id_q    <= own_id_d;
      lu_rd_q     <= lu_rd_d;
      own_valid_q <= own_valid_d;
      lu_busy_q   <= lu_busy_d;
      kcnt_q      <= kcnt_d;
      rdy_q       <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_scoreboard_hazard_unit_p.sv
// ----------------------------------------------------------------------------
// tb_scoreboard_hazard_unit_p : directed scoreboard bench for the hazard unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_scoreboard_hazard_unit_p;
  import scoreboard_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_valid = 1'b0;
  logic [6:0] op_code = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic [4:0] rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
  logic       btaken = 1'b0, exception = 1'b0, discard = 1'b0;
  logic [1:0] lu_done = 2'b00;
  logic       stall, kill, sb_busy;
  logic [1:0] lu_busy;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       stall;
    logic       kill;
    logic [1:0] lub;
    logic       sbb;
  } exp_t;

  exp_t exp_q[$];

  scoreboard_hazard_unit_p dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .op_code     (op_code),
    .funct3      (funct3),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .btaken      (btaken),
    .exception   (exception),
    .discard     (discard),
    .lu_done     (lu_done),
    .stall       (stall),
    .kill        (kill),
    .lu_busy     (lu_busy),
    .sb_busy     (sb_busy)
  );

  always #5 clk = ~clk;

  task automatic ins(input logic v, input logic [6:0] op, input logic [2:0] f3,
                     input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    issue_valid = v; op_code = op; funct3 = f3; rs1 = a; rs2 = b; rd = d;
  endtask

  task automatic expect_push(input logic s, input logic k, input logic [1:0] lb, input logic sb);
    exp_t e;
    e.stall = s; e.kill = k; e.lub = lb; e.sbb = sb;
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL %s queue got=empty exp=entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      assert (stall === e.stall) else begin
        failures++; $error("FAIL %s stall got=%b exp=%b", tag, stall, e.stall);
      end
      checks++;
      assert (kill === e.kill) else begin
        failures++; $error("FAIL %s kill got=%b exp=%b", tag, kill, e.kill);
      end
      checks++;
      assert (lu_busy === e.lub) else begin
        failures++; $error("FAIL %s lu_busy got=%b exp=%b", tag, lu_busy, e.lub);
      end
      checks++;
      assert (sb_busy === e.sbb) else begin
        failures++; $error("FAIL %s sb_busy got=%b exp=%b", tag, sb_busy, e.sbb);
      end
    end
  endtask

  // One clock cycle: inputs are already set, sample on the falling edge
  task automatic cyc(input string tag, input logic s, input logic k,
                     input logic [1:0] lb, input logic sb);
    expect_push(s, k, lb, sb);
    @(negedge clk);
    check(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk); #1;
    cyc("rst_hold", 0, 0, 2'b00, 0);
    rst = 1'b0;
    cyc("post_rst", 0, 0, 2'b00, 0);

    // RAW against fixed-latency writer, forwarding at countdown 1
    ins(1, OP_OP, 0, 1, 2, 5);   cyc("raw_w",  0, 0, 2'b00, 0);
    ins(1, OP_OP, 0, 5, 0, 6);   cyc("raw_c1", 1, 0, 2'b00, 1);
                                 cyc("raw_c2", 1, 0, 2'b00, 1);
                                 cyc("raw_c3", 0, 0, 2'b00, 1);
    ins(0, 0, 0, 0, 0, 0);       cyc("drn1", 0, 0, 2'b00, 1);
                                 cyc("drn2", 0, 0, 2'b00, 1);
                                 cyc("drn3", 0, 0, 2'b00, 1);
                                 cyc("drn_end", 0, 0, 2'b00, 0);

    // x0 is never tracked
    ins(1, OP_OPIMM, 0, 0, 0, 0); cyc("x0_w", 0, 0, 2'b00, 0);
    ins(1, OP_OP, 0, 0, 0, 0);    cyc("x0_r", 0, 0, 2'b00, 0);
    ins(0, 0, 0, 0, 0, 0);        cyc("x0_idle", 0, 0, 2'b00, 0);

    // Long unit ownership of x7
    ins(1, OP_CUSTOM0, 0, 1, 2, 7); cyc("lng_iss", 0, 0, 2'b00, 0);
    ins(1, OP_OPIMM, 0, 7, 0, 8);   cyc("lng_raw1", 1, 0, 2'b01, 1);
                                    cyc("lng_raw2", 1, 0, 2'b01, 1);
    lu_done = 2'b01;                cyc("lng_done", 1, 0, 2'b01, 1);
    lu_done = 2'b00;                cyc("lng_free", 0, 0, 2'b00, 0);
    ins(1, OP_CUSTOM0, 1, 0, 0, 10); cyc("lng_u1", 0, 0, 2'b00, 1);

    // Structural hazard and same-edge done/re-issue on unit 0
    ins(1, OP_CUSTOM0, 0, 0, 0, 7); cyc("lng_u0b", 0, 0, 2'b10, 1);
    ins(1, OP_CUSTOM0, 0, 0, 0, 9); cyc("struct", 1, 0, 2'b11, 1);
    lu_done = 2'b01;                cyc("same_cyc", 0, 0, 2'b11, 1);
    lu_done = 2'b00;
    ins(1, OP_OPIMM, 0, 7, 0, 0);   cyc("old_rel", 0, 0, 2'b11, 1);
    ins(1, OP_OPIMM, 0, 9, 0, 0);   cyc("new_own", 1, 0, 2'b11, 1);
    ins(1, OP_LUI, 0, 0, 0, 9);     cyc("waw", 1, 0, 2'b11, 1);
    ins(0, 0, 0, 0, 0, 0);
    lu_done = 2'b11;                cyc("done_all", 0, 0, 2'b11, 1);
    lu_done = 2'b00;                cyc("lu_idle", 0, 0, 2'b00, 0);

    // Kill window; killed writers leave no trace
    btaken = 1; ins(1, OP_OP, 0, 0, 0, 11); cyc("br_k0", 0, 1, 2'b00, 0);
    btaken = 0;                             cyc("br_k1", 0, 1, 2'b00, 0);
    ins(0, 0, 0, 0, 0, 0);                  cyc("br_k2", 0, 0, 2'b00, 0);
    btaken = 1;                             cyc("ext0", 0, 1, 2'b00, 0);
                                            cyc("ext1", 0, 1, 2'b00, 0);
    btaken = 0;                             cyc("ext2", 0, 1, 2'b00, 0);
                                            cyc("ext3", 0, 0, 2'b00, 0);
    exception = 1; ins(1, OP_OP, 0, 0, 0, 11); cyc("exc0", 0, 1, 2'b00, 0);
    exception = 0;                             cyc("exc1", 0, 1, 2'b00, 0);
    ins(0, 0, 0, 0, 0, 0);                     cyc("exc2", 0, 0, 2'b00, 0);

    // Redirect held off by a RAW stall
    ins(1, OP_OP, 0, 0, 0, 12);            cyc("sk_w", 0, 0, 2'b00, 0);
    ins(1, OP_OP, 0, 12, 0, 13); btaken = 1; cyc("sk_s1", 1, 0, 2'b00, 1);
                                           cyc("sk_s2", 1, 0, 2'b00, 1);
                                           cyc("sk_go", 0, 1, 2'b00, 1);
    btaken = 0; ins(0, 0, 0, 0, 0, 0);     cyc("sk_k2", 0, 1, 2'b00, 0);
                                           cyc("sk_end", 0, 0, 2'b00, 0);

    // Discard drops the redirect, including an active window
    btaken = 1; discard = 1;  cyc("disc0", 0, 0, 2'b00, 0);
    btaken = 0; discard = 0;  cyc("disc1", 0, 0, 2'b00, 0);
    btaken = 1;               cyc("dk0", 0, 1, 2'b00, 0);
    btaken = 0; discard = 1;  cyc("dk1", 0, 0, 2'b00, 0);
    discard = 0;              cyc("dk2", 0, 0, 2'b00, 0);

    // Asynchronous reset in the middle of a long op
    ins(1, OP_CUSTOM0, 0, 0, 0, 14); cyc("rl_iss", 0, 0, 2'b00, 0);
    ins(1, OP_OP, 0, 0, 0, 13);      cyc("rl_w", 0, 0, 2'b01, 1);
    ins(1, OP_OPIMM, 0, 14, 0, 0);
    expect_push(1, 0, 2'b01, 1);
    @(negedge clk);
    check("rl_stall");
    #1 rst = 1'b1;
    #1;
    expect_push(0, 0, 2'b00, 0);
    check("rl_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("rl_after", 0, 0, 2'b00, 0);
    ins(0, 0, 0, 0, 0, 0);
    cyc("rl_idle", 0, 0, 2'b00, 0);

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
